// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Jericalla memory-access stage. Data-RAM load/store with
//            configurable read wait states and a registered write-back word.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int ADDR_W      = 5,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        in_wE_BR,
    input  logic        in_W_ram,
    input  logic        in_R_ram,
    input  logic [31:0] in_DW_alu,
    input  logic [31:0] in_DR2,
    output logic        stall,
    output logic        out_valid,
    output logic        out_wE_BR,
    output logic [31:0] out_data
);

    localparam int c_depth    = 1 << ADDR_W;
    localparam int c_cnt_w    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int c_cnt_init = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [ADDR_W-1:0]    r_addr;
    logic [ADDR_W-1:0]    w_addr_nxt;
    logic                 r_we_cap;
    logic                 w_we_cap_nxt;
    logic                 w_valid_nxt;
    logic                 w_wbe_nxt;
    logic [31:0]          w_data_nxt;
    logic                 w_stall;
    logic                 w_ram_we;
    logic [ADDR_W-1:0]    w_addr;

    logic [31:0]          r_mem [0:c_depth-1];

    // Upper address bits are dropped so accesses wrap around the RAM.
    assign w_addr = in_DW_alu[ADDR_W-1:0];
    assign stall  = w_stall & rst_n;

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[w_addr] <= in_DR2;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_addr_nxt   = r_addr;
        w_we_cap_nxt = r_we_cap;
        w_valid_nxt  = 1'b0;
        w_wbe_nxt    = 1'b0;
        w_data_nxt   = out_data;
        w_stall      = 1'b0;
        w_ram_we     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_W_ram) begin
                        // Store takes priority over a simultaneous read.
                        w_ram_we    = rst_n;
                        w_valid_nxt = 1'b1;
                        w_wbe_nxt   = in_wE_BR;
                        w_data_nxt  = in_DW_alu;
                    end else if (in_R_ram) begin
                        if (WAIT_CYCLES == 0) begin
                            w_valid_nxt = 1'b1;
                            w_wbe_nxt   = in_wE_BR;
                            w_data_nxt  = r_mem[w_addr];
                        end else begin
                            w_stall      = 1'b1;
                            w_addr_nxt   = w_addr;
                            w_we_cap_nxt = in_wE_BR;
                            w_cnt_nxt    = c_cnt_w'(c_cnt_init);
                            w_state_nxt  = S_WAIT;
                        end
                    end else begin
                        w_valid_nxt = 1'b1;
                        w_wbe_nxt   = in_wE_BR;
                        w_data_nxt  = in_DW_alu;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt != '0) begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt - c_cnt_w'(1);
                end else begin
                    w_valid_nxt = 1'b1;
                    w_wbe_nxt   = r_we_cap;
                    w_data_nxt  = r_mem[r_addr];
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_we_cap  <= 1'b0;
            out_valid <= 1'b0;
            out_wE_BR <= 1'b0;
            out_data  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_addr    <= w_addr_nxt;
            r_we_cap  <= w_we_cap_nxt;
            out_valid <= w_valid_nxt;
            out_wE_BR <= w_wbe_nxt;
            out_data  <= w_data_nxt;
        end
    end

endmodule
`default_nettype wire
